// File: rtl/sprite_pkg.sv
// ============================================================================
// sprite_pkg
//   Shared types and helpers for the sprite layer engine.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package sprite_pkg;

  localparam int COORD_W_DEF    = 10;
  localparam int COLOR_BITS_DEF = 6;

  typedef logic [COLOR_BITS_DEF-1:0] color_t;
  typedef logic [23:0]               rgb_t;

  typedef struct packed {
    logic                   en;
    logic                   anim;
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
  } sprite_cfg_t;

  // ROM address width: frame index, row and column fields concatenated.
  function automatic int sprite_aw(input int frames, input int w, input int h);
    return $clog2(frames * w * h);
  endfunction

  // Each 2-bit channel is replicated to 8 bits so 2'b11 maps to full scale.
  function automatic rgb_t expand_rgb222(input color_t c);
    return {{4{c[5:4]}}, {4{c[3:2]}}, {4{c[1:0]}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_layer_engine_channel.sv
// ============================================================================
// sprite_channel
//   One sprite channel: shadow/active config, animation frame, hit + address
//   stage and opacity test on the returned ROM texel.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module sprite_channel
  import sprite_pkg::*;
#(
  parameter int   SPRITE_W    = 64,
  parameter int   SPRITE_H    = 64,
  parameter int   FRAMES      = 4,
  parameter int   COORD_W     = COORD_W_DEF,
  parameter int   COLOR_BITS  = COLOR_BITS_DEF,
  parameter logic [COLOR_BITS-1:0] TRANSPARENT = '0,
  parameter int   AW          = sprite_aw(FRAMES, SPRITE_W, SPRITE_H)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start_i,
  input  logic                  anim_step_i,
  input  logic                  cfg_we_i,
  input  logic                  cfg_en_i,
  input  logic                  cfg_anim_i,
  input  logic [COORD_W-1:0]    cfg_x_i,
  input  logic [COORD_W-1:0]    cfg_y_i,
  input  logic [COORD_W-1:0]    pix_x_i,
  input  logic [COORD_W-1:0]    pix_y_i,
  input  logic [COLOR_BITS-1:0] rom_data_i,
  output logic [AW-1:0]         rom_addr_o,
  output logic                  opaque_o
);

  localparam int FW = $clog2(FRAMES);
  localparam int XW = $clog2(SPRITE_W);
  localparam int YW = $clog2(SPRITE_H);

  sprite_cfg_t     shadow_q, shadow_d;
  sprite_cfg_t     active_q, active_d;
  logic            pend_q, pend_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic            hit_s1_q, hit_s2_q;
  logic            hit_d;
  logic [COORD_W:0] dx, dy;

  always_comb begin
    shadow_d = shadow_q;
    pend_d   = pend_q;
    active_d = active_q;
    frame_d  = frame_q;
    if (cfg_we_i) begin
      shadow_d = '{en: cfg_en_i, anim: cfg_anim_i, x: cfg_x_i, y: cfg_y_i};
      pend_d   = 1'b1;
    end
    // A write landing on the commit cycle is folded straight into active.
    if (frame_start_i) begin
      active_d = shadow_d;
      pend_d   = 1'b0;
      if (pend_q || cfg_we_i) begin
        frame_d = '0;
      end else if (anim_step_i && active_d.en && active_d.anim) begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  // The extra MSB is a borrow: a sprite near the right edge never wraps to x=0.
  always_comb begin
    dx         = {1'b0, pix_x_i} - {1'b0, active_q.x};
    dy         = {1'b0, pix_y_i} - {1'b0, active_q.y};
    hit_d      = active_q.en && !dx[COORD_W] && !dy[COORD_W] &&
                 (dx[COORD_W-1:0] < COORD_W'(SPRITE_W)) &&
                 (dy[COORD_W-1:0] < COORD_W'(SPRITE_H));
    rom_addr_d = {frame_q, dy[YW-1:0], dx[XW-1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q   <= '0;
      active_q   <= '0;
      pend_q     <= 1'b0;
      frame_q    <= '0;
      rom_addr_q <= '0;
      hit_s1_q   <= 1'b0;
      hit_s2_q   <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      frame_q    <= frame_d;
      rom_addr_q <= rom_addr_d;
      hit_s1_q   <= hit_d;
      hit_s2_q   <= hit_s1_q;
    end
  end

  assign rom_addr_o = rom_addr_q;
  assign opaque_o   = hit_s2_q && (rom_data_i != TRANSPARENT);

endmodule

`default_nettype wire

// File: rtl/sprite_layer_engine.sv
// ============================================================================
// sprite_layer_engine
//   N-channel sprite renderer: per-channel hit/ROM fetch, fixed-priority
//   resolve and RGB expansion with a 3-cycle pixel latency.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module sprite_layer_engine
  import sprite_pkg::*;
#(
  parameter int   NUM_SPRITES = 4,
  parameter int   SPRITE_W    = 64,
  parameter int   SPRITE_H    = 64,
  parameter int   FRAMES      = 4,
  parameter int   COORD_W     = COORD_W_DEF,
  parameter int   COLOR_BITS  = COLOR_BITS_DEF,
  parameter int   FRAME_DIV   = 15,
  parameter logic [COLOR_BITS-1:0] TRANSPARENT = 6'h00,
  localparam int  AW          = sprite_aw(FRAMES, SPRITE_W, SPRITE_H),
  localparam int  IDX_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pix_valid,
  input  logic [COORD_W-1:0]                pix_x,
  input  logic [COORD_W-1:0]                pix_y,
  input  logic                              frame_start,
  input  logic                              cfg_we,
  input  logic [IDX_W-1:0]                  cfg_idx,
  input  logic                              cfg_en,
  input  logic                              cfg_anim,
  input  logic [COORD_W-1:0]                cfg_x,
  input  logic [COORD_W-1:0]                cfg_y,
  output logic [NUM_SPRITES*AW-1:0]         rom_addr,
  input  logic [NUM_SPRITES*COLOR_BITS-1:0] rom_data,
  output logic                              out_valid,
  output logic                              visible,
  output logic [IDX_W-1:0]                  sprite_id,
  output logic [23:0]                       rgb
);

  localparam int DIV_W = $clog2(FRAME_DIV + 1);

  logic [DIV_W-1:0]       div_q, div_d;
  logic                   anim_step;
  logic                   valid_s1_q, valid_s2_q;
  logic [NUM_SPRITES-1:0] opaque;
  logic                   win_found;
  logic [IDX_W-1:0]       win_id;
  color_t                 win_color;
  logic                   out_valid_q, visible_q, visible_d;
  logic [IDX_W-1:0]       sprite_id_q, sprite_id_d;
  rgb_t                   rgb_q, rgb_d;

  always_comb begin
    div_d     = div_q;
    anim_step = frame_start && (div_q == DIV_W'(FRAME_DIV - 1));
    if (frame_start) begin
      div_d = anim_step ? '0 : div_q + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_channel
    sprite_channel #(
      .SPRITE_W    (SPRITE_W),
      .SPRITE_H    (SPRITE_H),
      .FRAMES      (FRAMES),
      .COORD_W     (COORD_W),
      .COLOR_BITS  (COLOR_BITS),
      .TRANSPARENT (TRANSPARENT),
      .AW          (AW)
    ) u_channel (
      .clk           (clk),
      .rst           (rst),
      .frame_start_i (frame_start),
      .anim_step_i   (anim_step),
      .cfg_we_i      (cfg_we && (cfg_idx == IDX_W'(g))),
      .cfg_en_i      (cfg_en),
      .cfg_anim_i    (cfg_anim),
      .cfg_x_i       (cfg_x),
      .cfg_y_i       (cfg_y),
      .pix_x_i       (pix_x),
      .pix_y_i       (pix_y),
      .rom_data_i    (rom_data[g*COLOR_BITS +: COLOR_BITS]),
      .rom_addr_o    (rom_addr[g*AW +: AW]),
      .opaque_o      (opaque[g])
    );
  end

  // Scan from the lowest priority upward so channel 0 overwrites last.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_color = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        win_found = 1'b1;
        win_id    = IDX_W'(i);
        win_color = rom_data[i*COLOR_BITS +: COLOR_BITS];
      end
    end
    visible_d   = valid_s2_q && win_found;
    sprite_id_d = visible_d ? win_id : '0;
    rgb_d       = visible_d ? expand_rgb222(win_color) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q       <= '0;
      valid_s1_q  <= 1'b0;
      valid_s2_q  <= 1'b0;
      out_valid_q <= 1'b0;
      visible_q   <= 1'b0;
      sprite_id_q <= '0;
      rgb_q       <= '0;
    end else begin
      div_q       <= div_d;
      valid_s1_q  <= pix_valid;
      valid_s2_q  <= valid_s1_q;
      out_valid_q <= valid_s2_q;
      visible_q   <= visible_d;
      sprite_id_q <= sprite_id_d;
      rgb_q       <= rgb_d;
    end
  end

  assign out_valid = out_valid_q;
  assign visible   = visible_q;
  assign sprite_id = sprite_id_q;
  assign rgb       = rgb_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_layer_engine.sv
// ============================================================================
// tb_sprite_layer_engine
//   Randomised self-checking bench with a screen-space reference model.
//   Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sprite_layer_engine;

  localparam int N = 4, W = 64, H = 64, FR = 4, CW = 10, CB = 6, FDIV = 15;
  localparam int AW = 14, IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            pix_valid, frame_start, cfg_we, cfg_en, cfg_anim;
  logic [CW-1:0]   pix_x, pix_y, cfg_x, cfg_y;
  logic [IW-1:0]   cfg_idx;
  logic [N*AW-1:0] rom_addr;
  logic [N*CB-1:0] rom_data;
  logic            out_valid, visible;
  logic [IW-1:0]   sprite_id;
  logic [23:0]     rgb;

  always #5 clk = ~clk;

  sprite_layer_engine dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_anim(cfg_anim), .cfg_x(cfg_x), .cfg_y(cfg_y), .rom_addr(rom_addr),
    .rom_data(rom_data), .out_valid(out_valid), .visible(visible),
    .sprite_id(sprite_id), .rgb(rgb)
  );

  logic [CB-1:0] rom   [N][FR*W*H];
  logic [CB-1:0] rom_q [N];

  for (genvar g = 0; g < N; g++) begin : g_rom
    always @(posedge clk) rom_q[g] <= rom[g][rom_addr[g*AW +: AW]];
    assign rom_data[g*CB +: CB] = rom_q[g];
  end

  // Reference model state (screen-space view of each channel).
  int sh_en[N], sh_an[N], sh_x[N], sh_y[N];
  int ac_en[N], ac_an[N], ac_x[N], ac_y[N];
  int fr[N], pend[N], div_cnt;

  logic [27:0] expq[$];
  logic [27:0] exp_due, obs;
  bit          due_v;
  int          checks = 0, errors = 0;

  function automatic logic [27:0] model_pixel(input bit v, input int px, input int py);
    logic [27:0] r;
    int dx, dy, col;
    r = '0;
    if (!v) return r;
    r[27] = 1'b1;
    for (int c = 0; c < N; c++) begin
      dx = px - ac_x[c];
      dy = py - ac_y[c];
      if (ac_en[c] != 0 && dx >= 0 && dx < W && dy >= 0 && dy < H) begin
        col = int'(rom[c][fr[c]*W*H + dy*W + dx]);
        if (col != 0) begin
          r[26]     = 1'b1;
          r[25:24]  = c[1:0];
          r[23:16]  = 8'(((col >> 4) & 3) * 85);
          r[15:8]   = 8'(((col >> 2) & 3) * 85);
          r[7:0]    = 8'((col & 3) * 85);
          return r;
        end
      end
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < N; c++) begin
      sh_en[c] = 0; sh_an[c] = 0; sh_x[c] = 0; sh_y[c] = 0;
      ac_en[c] = 0; ac_an[c] = 0; ac_x[c] = 0; ac_y[c] = 0;
      fr[c] = 0; pend[c] = 0;
    end
    div_cnt = 0;
    expq.delete();
  endtask

  task automatic step(input bit v, input int x, input int y, input bit fs, input bit we,
                      input int idx, input bit en, input bit an, input int cx, input int cy);
    bit wrap;
    pix_valid = v; pix_x = x[CW-1:0]; pix_y = y[CW-1:0];
    frame_start = fs; cfg_we = we; cfg_idx = idx[IW-1:0];
    cfg_en = en; cfg_anim = an; cfg_x = cx[CW-1:0]; cfg_y = cy[CW-1:0];
    expq.push_back(model_pixel(v, x, y));
    if (we) begin
      sh_en[idx] = en; sh_an[idx] = an; sh_x[idx] = cx; sh_y[idx] = cy; pend[idx] = 1;
    end
    if (fs) begin
      wrap = (div_cnt == FDIV - 1);
      div_cnt = wrap ? 0 : div_cnt + 1;
      for (int c = 0; c < N; c++) begin
        ac_en[c] = sh_en[c]; ac_an[c] = sh_an[c]; ac_x[c] = sh_x[c]; ac_y[c] = sh_y[c];
        if (pend[c] != 0) begin
          fr[c] = 0; pend[c] = 0;
        end else if (wrap && ac_en[c] != 0 && ac_an[c] != 0) begin
          fr[c] = (fr[c] + 1) % FR;
        end
      end
    end
    @(posedge clk); #1;
    obs = {out_valid, visible, sprite_id, rgb};
    if (expq.size() == 3) begin
      exp_due = expq.pop_front();
      due_v = 1'b1;
    end else begin
      due_v = 1'b0;
    end
  endtask

  task automatic pix(input bit v, input int x, input int y);
    step(v, x, y, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fs_pulse();
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cfg(input int idx, input bit en, input bit an, input int cx, input int cy);
    step(0, 0, 0, 0, 1, idx, en, an, cx, cy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pix_valid = 0; pix_x = '0; pix_y = '0; frame_start = 0; cfg_we = 0;
    cfg_idx = '0; cfg_en = 0; cfg_anim = 0; cfg_x = '0; cfg_y = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (visible !== 1'b0) begin errors++; $display("FAIL reset_visible got %b exp 0", visible); end
    checks++; if (sprite_id !== '0) begin errors++; $display("FAIL reset_sprite_id got %0d exp 0", sprite_id); end
    checks++; if (rgb !== '0) begin errors++; $display("FAIL reset_rgb got %h exp 0", rgb); end
    checks++; if (rom_addr !== '0) begin errors++; $display("FAIL reset_rom_addr got %h exp 0", rom_addr); end
    do_reset();
  endtask

  task automatic test_bubbles();
    for (int i = 0; i < 24; i++) begin
      pix($urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 1023));
      if (due_v) begin
        checks++;
        if (obs !== exp_due) begin errors++; $display("FAIL bubbles got %h exp %h", obs, exp_due); end
      end
    end
  endtask

  task automatic test_basic();
    rom[0][0] = 6'h2d;
    cfg(0, 1, 0, 100, 50);
    fs_pulse();
    pix(1, 100, 50); pix(1, 164, 50); pix(1, 163, 113); pix(0, 100, 50);
    for (int i = 0; i < 12; i++) begin
      pix(1, $urandom_range(90, 170), $urandom_range(40, 120));
      if (due_v) begin
        checks++;
        if (obs !== exp_due) begin errors++; $display("FAIL basic got %h exp %h", obs, exp_due); end
      end
    end
  endtask

  task automatic test_priority();
    rom[0][0] = 6'h00;
    rom[1][0] = 6'h15;
    cfg(0, 1, 0, 200, 200);
    cfg(1, 1, 0, 200, 200);
    fs_pulse();
    for (int k = 0; k < 2; k++) begin
      pix(1, 200, 200);
      for (int i = 0; i < 3; i++) begin
        pix(0, 0, 0);
        if (due_v) begin
          checks++;
          if (obs !== exp_due) begin errors++; $display("FAIL priority got %h exp %h", obs, exp_due); end
        end
      end
      rom[0][0] = 6'h3f;
    end
  endtask

  task automatic test_commit();
    cfg(0, 1, 0, 300, 0);
    for (int k = 0; k < 2; k++) begin
      pix(1, 200, 200); pix(1, 300, 0); pix(1, 330, 40);
      for (int i = 0; i < 6; i++) begin
        pix(i < 3, $urandom_range(190, 340), $urandom_range(0, 210));
        if (due_v) begin
          checks++;
          if (obs !== exp_due) begin errors++; $display("FAIL commit got %h exp %h", obs, exp_due); end
        end
      end
      fs_pulse();
    end
  endtask

  task automatic test_edge();
    rom[3][3] = 6'h27;
    cfg(3, 1, 0, 1020, 100);
    fs_pulse();
    pix(1, 1023, 100);
    checks++;
    if (rom_addr[3*AW +: AW] !== AW'(fr[3]*W*H + 3)) begin
      errors++; $display("FAIL edge_addr got %h exp %h", rom_addr[3*AW +: AW], AW'(fr[3]*W*H + 3));
    end
    pix(1, 2, 100); pix(1, 1020, 163); pix(1, 1, 101);
    for (int i = 0; i < 6; i++) begin
      pix(0, 0, 0);
      if (due_v) begin
        checks++;
        if (obs !== exp_due) begin errors++; $display("FAIL edge got %h exp %h", obs, exp_due); end
      end
    end
  endtask

  task automatic test_random();
    int c, r, x, y;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      c = $urandom_range(0, N-1);
      x = ac_x[c] + $urandom_range(0, 80) - 8;
      y = ac_y[c] + $urandom_range(0, 80) - 8;
      x = (x < 0) ? 0 : (x > 1023 ? 1023 : x);
      y = (y < 0) ? 0 : (y > 1023 ? 1023 : y);
      step($urandom_range(0, 4) != 0, x, y, r < 4 || r == 99, r >= 94, $urandom_range(0, N-1),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1023),
           $urandom_range(0, 479));
      if (due_v) begin
        checks++;
        if (obs !== exp_due) begin errors++; $display("FAIL random got %h exp %h", obs, exp_due); end
      end
    end
  endtask

  task automatic test_anim();
    int ea;
    do_reset();
    cfg(0, 1, 1, 0, 0);
    for (int p = 1; p <= 60; p++) begin
      fs_pulse();
      if (p == 1 || p == 14 || p == 15 || p == 16 || p == 30 || p == 45 || p == 59 || p == 60) begin
        pix(1, 5, 5);
        ea = fr[0]*W*H + 5*W + 5;
        checks++;
        if (rom_addr[AW-1:0] !== AW'(ea)) begin
          errors++; $display("FAIL anim_p%0d got %h exp %h", p, rom_addr[AW-1:0], AW'(ea));
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    cfg(1, 1, 0, 50, 50);
    fs_pulse();
    pix(1, 50, 50); pix(1, 51, 50); pix(1, 52, 50);
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", out_valid); end
    checks++; if (visible !== 1'b0) begin errors++; $display("FAIL midrst_visible got %b exp 0", visible); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_hold got %b exp 0", out_valid); end
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 6; i++) begin
      pix(1, 50 + i, 50);
      if (i < 2) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale got %b exp 0", out_valid); end
      end
      if (due_v) begin
        checks++;
        if (obs !== exp_due) begin errors++; $display("FAIL midrst got %h exp %h", obs, exp_due); end
      end
    end
  endtask

  initial begin
    for (int c = 0; c < N; c++)
      for (int a = 0; a < FR*W*H; a++)
        rom[c][a] = ($urandom_range(0, 7) == 0) ? 6'h00 : 6'($urandom_range(0, 63));
    model_clear();
    test_reset();
    test_bubbles();
    test_basic();
    test_priority();
    test_commit();
    test_edge();
    test_random();
    test_anim();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
